// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 serial receiver, LSB first, line idles high.
//
// Finds the falling edge of a start bit, then re-checks the line half a bit
// later to reject glitches. Each data bit is sampled in the middle of its bit
// period, and the stop bit is checked last. A good frame updates rx_data and
// pulses rx_valid. A low stop bit pulses frame_err, and the receiver then
// waits in BREAK until the line goes high again.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per serial bit (>= 4)
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous reset, active low
//   rx        in   asynchronous serial line
//   rx_data   out  [7:0] last correctly framed byte, held until next good frame
//   rx_valid  out  one-cycle pulse when rx_data is updated
//   frame_err out  one-cycle pulse when the stop bit is sampled low
//   busy      out  high while the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_rx_meta;
   logic            r_rx_sync;
   logic [CW-1:0]   r_clk_cnt;
   logic [2:0]      r_bit_idx;
   logic [7:0]      r_shift;

   logic            w_cnt_clr;
   logic            w_sample;
   logic            w_good;
   logic            w_err;
   logic            w_at_bit;
   logic            w_at_half;
   logic            w_enter_data;

   assign w_at_bit     = (r_clk_cnt == CNT_BIT);
   assign w_at_half    = (r_clk_cnt == CNT_HALF);
   assign w_enter_data = (r_state != S_DATA) && (w_state_nxt == S_DATA);

   // State register
   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic and datapath strobes. The counter is held at zero in
   // IDLE and BREAK, so it never runs past CLKS_PER_BIT-1.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_clr   = 1'b0;
      w_sample    = 1'b0;
      w_good      = 1'b0;
      w_err       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_clr = 1'b1;
            if (!r_rx_sync) w_state_nxt = S_START;
         end
         S_START: begin
            // Mid start bit: confirm that the line is still low, or drop it as a glitch
            if (w_at_half) begin
               w_cnt_clr   = 1'b1;
               w_state_nxt = r_rx_sync ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (w_at_bit) begin
               w_cnt_clr = 1'b1;
               w_sample  = 1'b1;
               if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (w_at_bit) begin
               w_cnt_clr = 1'b1;
               if (r_rx_sync) begin
                  w_good      = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_err       = 1'b1;
                  w_state_nxt = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            // Line held low after a bad stop: ignore it until it returns high
            w_cnt_clr = 1'b1;
            if (r_rx_sync) w_state_nxt = S_IDLE;
         end
         default: begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Synchronizer, counters, shift register, outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_clk_cnt <= '0;
         r_bit_idx <= 3'd0;
         r_shift   <= 8'h00;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         r_rx_meta <= rx;
         r_rx_sync <= r_rx_meta;

         if (w_cnt_clr || (w_state_nxt != r_state)) r_clk_cnt <= '0;
         else                                        r_clk_cnt <= r_clk_cnt + 1'b1;

         if (w_enter_data)  r_bit_idx <= 3'd0;
         else if (w_sample) r_bit_idx <= r_bit_idx + 3'd1;

         if (w_sample) r_shift[r_bit_idx] <= r_rx_sync;

         if (w_good) rx_data <= r_shift;
         rx_valid  <= w_good;
         frame_err <= w_err;
      end
   end

   assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       busy;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      logic [7:0] d;
      int         t0;
   } exp_t;

   exp_t sb[$];
   int   vtimes[$];
   int   nvalid = 0;
   int   nerr = 0;
   int   nbusy = 0;
   exp_t m_e;
   int   m_lat;

   // Monitor: compares every rx_valid pulse against the scoreboard
   always @(negedge clk) begin
      if (rx_valid && frame_err) chk("both_pulses", 32'd1, 32'd0);
      if (frame_err) nerr++;
      if (busy) nbusy++;
      if (rx_valid) begin
         nvalid++;
         vtimes.push_back(cyc);
         if (sb.size() == 0) begin
            chk("unexpected_valid", 32'd1, 32'd0);
         end else begin
            m_e   = sb.pop_front();
            m_lat = cyc - m_e.t0;
            chk("rx_data", {24'd0, rx_data}, {24'd0, m_e.d});
            chk("latency_149_155", {31'd0, (m_lat >= 149 && m_lat <= 155)}, 32'd1);
         end
      end
   end

   task automatic send_bit(input logic b);
      rx = b;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b, input bit expect_ok);
      exp_t e;
      e.d  = d;
      e.t0 = cyc;
      if (expect_ok) sb.push_back(e);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop_b);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int v0, e0, b0, ti;
      reset = 1'b0;
      rx    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
      chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b1;
      idle(20);

      // Single frame 0xA5
      v0 = nvalid;
      send_frame(8'hA5, 1'b1, 1'b1);
      idle(20);
      chk("a5_pulses", nvalid - v0, 32'd1);
      chk("a5_data", {24'd0, rx_data}, 32'hA5);
      chk("a5_no_ferr", nerr, 32'd0);

      // Back-to-back 0x00, 0xFF
      v0 = nvalid;
      ti = vtimes.size();
      send_frame(8'h00, 1'b1, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b1);
      idle(20);
      chk("b2b_pulses", nvalid - v0, 32'd2);
      if (nvalid - v0 == 2) chk("b2b_gap", vtimes[ti+1] - vtimes[ti], 32'd160);
      chk("b2b_data", {24'd0, rx_data}, 32'hFF);

      // Start-bit glitch: 4 clk low
      v0 = nvalid;
      e0 = nerr;
      b0 = nbusy;
      rx = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rx = 1'b1;
      idle(30);
      chk("glitch_busy_brief", {31'd0, (nbusy - b0 >= 6 && nbusy - b0 <= 10)}, 32'd1);
      chk("glitch_idle", {31'd0, busy}, 32'd0);
      chk("glitch_no_valid", nvalid - v0, 32'd0);
      chk("glitch_no_ferr", nerr - e0, 32'd0);
      chk("glitch_data_held", {24'd0, rx_data}, 32'hFF);

      // Framing error then break, then recovery
      send_frame(8'h11, 1'b1, 1'b1);
      idle(10);
      chk("pre_err_data", {24'd0, rx_data}, 32'h11);
      v0 = nvalid;
      e0 = nerr;
      send_frame(8'h3C, 1'b0, 1'b0);
      rx = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      chk("break_ferr_once", nerr - e0, 32'd1);
      chk("break_busy", {31'd0, busy}, 32'd1);
      chk("break_no_valid", nvalid - v0, 32'd0);
      chk("break_data_held", {24'd0, rx_data}, 32'h11);
      idle(40);
      chk("break_released", {31'd0, busy}, 32'd0);
      send_frame(8'h55, 1'b1, 1'b1);
      idle(20);
      chk("after_break_data", {24'd0, rx_data}, 32'h55);
      chk("after_break_ferr", nerr - e0, 32'd1);
      chk("after_break_pulses", nvalid - v0, 32'd1);

      // Reset pulse during data bit 3
      v0 = nvalid;
      e0 = nerr;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      rx = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      chk("midrst_rx_data", {24'd0, rx_data}, 32'h00);
      chk("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      idle(200);
      chk("midrst_no_valid", nvalid - v0, 32'd0);
      chk("midrst_no_ferr", nerr - e0, 32'd0);
      send_frame(8'h81, 1'b1, 1'b1);
      idle(20);
      chk("post_rst_data", {24'd0, rx_data}, 32'h81);
      chk("post_rst_pulses", nvalid - v0, 32'd1);

      chk("sb_empty", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
